i2c_slave: RTL and testbench

I2C target (responder) that pairs with `i2c_master` and sits on the same SCL/SDA pair. It oversamples SCL and SDA with the system clock and detects START, STOP and repeated START. It matches a fixed 7-bit address and ACKs it. On a write it receives data bytes and hands them to local logic; on a read it shifts out bytes supplied by local logic.

---
 rtl/i2c_slave.sv | 182 ++++++++++++++++++
 tb/tb_i2c_slave.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// I2C target with a fixed 7-bit address, oversampling SCL/SDA on clk.
// Write bytes appear on rx_data/rx_valid; read bytes are fetched through tx_req/tx_data.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'b1010000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_out,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ACK_ADDR  = 4'd2,
    RX_BYTE   = 4'd3,
    ACK_RX    = 4'd4,
    TX_BYTE   = 4'd5,
    MACK      = 4'd6,
    WAIT_STOP = 4'd7
  } state_t;

  state_t     state_r;
  logic [2:0] scl_sync_r;
  logic [2:0] sda_sync_r;
  logic [7:0] shift_r;
  logic [3:0] bit_cnt_r;
  logic       rw_r;
  logic       scl_rise_s;
  logic       scl_fall_s;
  logic       start_s;
  logic       stop_s;
  logic       sda_s;
  logic [7:0] rx_byte_s;

  // Synchronizer flops reset to the idle-bus level so reset cannot fake an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_r <= 3'b111;
      sda_sync_r <= 3'b111;
    end else begin
      scl_sync_r <= {scl_sync_r[1:0], scl};
      sda_sync_r <= {sda_sync_r[1:0], sda_in};
    end
  end

  assign sda_s      = sda_sync_r[1];
  assign scl_rise_s = scl_sync_r[1] & ~scl_sync_r[2];
  assign scl_fall_s = ~scl_sync_r[1] & scl_sync_r[2];
  assign start_s    = scl_sync_r[1] & scl_sync_r[2] & sda_sync_r[2] & ~sda_sync_r[1];
  assign stop_s     = scl_sync_r[1] & scl_sync_r[2] & ~sda_sync_r[2] & sda_sync_r[1];
  assign rx_byte_s  = {shift_r[6:0], sda_s};
  assign state      = state_r;
  assign sda_out    = ~sda_oe;

  // Protocol FSM: STOP beats START, which beats any SCL edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      shift_r   <= 8'h00;
      bit_cnt_r <= 4'd0;
      rw_r      <= 1'b0;
      sda_oe    <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      if (stop_s) begin
        state_r   <= IDLE;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
        bit_cnt_r <= 4'd0;
      end else if (start_s) begin
        state_r   <= ADDR;
        sda_oe    <= 1'b0;
        bit_cnt_r <= 4'd0;
        shift_r   <= 8'h00;
      end else begin
        case (state_r)
          ADDR: begin
            if (scl_rise_s) begin
              shift_r   <= rx_byte_s;
              bit_cnt_r <= bit_cnt_r + 4'd1;
              if (bit_cnt_r == 4'd7) begin
                bit_cnt_r <= 4'd0;
                if (rx_byte_s[7:1] == SLAVE_ADDR) begin
                  state_r <= ACK_ADDR;
                  busy    <= 1'b1;
                  rw_r    <= rx_byte_s[0];
                  if (rx_byte_s[0]) begin
                    tx_req  <= 1'b1;
                    shift_r <= tx_data;
                  end
                end else begin
                  state_r <= WAIT_STOP;
                  busy    <= 1'b0;
                end
              end
            end
          end
          // First fall pulls SDA for the ACK clock, second fall ends it.
          ACK_ADDR, ACK_RX: begin
            if (scl_fall_s) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else if (state_r == ACK_ADDR && rw_r) begin
                state_r   <= TX_BYTE;
                sda_oe    <= ~shift_r[7];
                bit_cnt_r <= 4'd1;
              end else begin
                state_r   <= RX_BYTE;
                sda_oe    <= 1'b0;
                bit_cnt_r <= 4'd0;
              end
            end
          end
          RX_BYTE: begin
            if (scl_rise_s) begin
              shift_r   <= rx_byte_s;
              bit_cnt_r <= bit_cnt_r + 4'd1;
              if (bit_cnt_r == 4'd7) begin
                rx_data   <= rx_byte_s;
                rx_valid  <= 1'b1;
                state_r   <= ACK_RX;
                bit_cnt_r <= 4'd0;
              end
            end
          end
          // bit_cnt_r counts bits already placed on SDA; 0 means MSB not yet driven.
          TX_BYTE: begin
            if (scl_fall_s) begin
              if (bit_cnt_r == 4'd8) begin
                sda_oe    <= 1'b0;
                state_r   <= MACK;
                bit_cnt_r <= 4'd0;
              end else if (bit_cnt_r == 4'd0) begin
                sda_oe    <= ~shift_r[7];
                bit_cnt_r <= 4'd1;
              end else begin
                sda_oe    <= ~shift_r[6];
                shift_r   <= {shift_r[6:0], 1'b0};
                bit_cnt_r <= bit_cnt_r + 4'd1;
              end
            end
          end
          MACK: begin
            if (scl_rise_s) begin
              if (!sda_s) begin
                tx_req    <= 1'b1;
                shift_r   <= tx_data;
                state_r   <= TX_BYTE;
                bit_cnt_r <= 4'd0;
              end else begin
                busy    <= 1'b0;
                state_r <= WAIT_STOP;
              end
            end
          end
          IDLE, WAIT_STOP: begin
            state_r <= state_r;
          end
          default: begin
            state_r <= IDLE;
            sda_oe  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench: bit-banged I2C master against i2c_slave with hand-computed expectations.
module tb_i2c_slave;

  logic       clk;
  logic       reset;
  logic       scl_m;
  logic       sda_m;
  logic       sda_line;
  logic       sda_out;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       busy;
  logic [3:0] state;

  int n_tests = 0;
  int n_fail  = 0;
  int rx_cnt  = 0;
  int tx_cnt  = 0;
  int oe_cnt  = 0;

  assign sda_line = (sda_oe ? sda_out : 1'b1) & sda_m;

  i2c_slave #(.SLAVE_ADDR(7'b1010000)) dut (
    .clk      (clk),
    .reset    (reset),
    .scl      (scl_m),
    .sda_in   (sda_line),
    .sda_out  (sda_out),
    .sda_oe   (sda_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .busy     (busy),
    .state    (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Strobe cycle counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_valid) rx_cnt <= rx_cnt + 1;
    if (tx_req)   tx_cnt <= tx_cnt + 1;
    if (sda_oe)   oe_cnt <= oe_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    cyc(5); sda_m = 1'b1;
    cyc(5); scl_m = 1'b1;
    cyc(8); sda_m = 1'b0;
    cyc(8); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    cyc(5); sda_m = 1'b0;
    cyc(5); scl_m = 1'b1;
    cyc(8); sda_m = 1'b1;
    cyc(8);
  endtask

  task automatic write_bit(input logic b);
    cyc(5); sda_m = b;
    cyc(5); scl_m = 1'b1;
    cyc(8); scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    cyc(5); sda_m = 1'b1;
    cyc(5); scl_m = 1'b1;
    cyc(4); ack = ~sda_line;
    cyc(4); scl_m = 1'b0;
  endtask

  task automatic read_byte(output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      cyc(5); sda_m = 1'b1;
      cyc(5); scl_m = 1'b1;
      cyc(4); d[i] = sda_line;
      cyc(4); scl_m = 1'b0;
    end
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd;
    int         rx0;
    int         tx0;
    int         oe0;
    logic [7:0] v3c;
    reset   = 1'b1;
    scl_m   = 1'b1;
    sda_m   = 1'b1;
    tx_data = 8'h00;
    cyc(3);
    check_val("rst_state", 32'(state), 32'd0);
    check_val("rst_oe", 32'(sda_oe), 32'd0);
    check_val("rst_sda_out", 32'(sda_out), 32'd1);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_rx_data", 32'(rx_data), 32'h00);
    check_val("rst_strobes", 32'({rx_valid, tx_req}), 32'd0);
    reset = 1'b0;
    cyc(4);

    // Write 0x3C to address 0x50
    rx0 = rx_cnt;
    i2c_start();
    check_val("wr_start_state", 32'(state), 32'd1);
    write_byte(8'hA0, ack);
    check_val("wr_addr_ack", 32'(ack), 32'd1);
    cyc(5);
    check_val("wr_busy", 32'(busy), 32'd1);
    check_val("wr_state_rx", 32'(state), 32'd3);
    write_byte(8'h3C, ack);
    check_val("wr_data_ack", 32'(ack), 32'd1);
    cyc(5);
    check_val("wr_rx_data", 32'(rx_data), 32'h3C);
    check_val("wr_rx_pulses", 32'(rx_cnt - rx0), 32'd1);
    i2c_stop();
    check_val("wr_stop_busy", 32'(busy), 32'd0);
    check_val("wr_stop_state", 32'(state), 32'd0);

    // Address mismatch: 0x51
    rx0 = rx_cnt;
    oe0 = oe_cnt;
    i2c_start();
    write_byte(8'hA2, ack);
    check_val("mm_addr_nack", 32'(ack), 32'd0);
    cyc(5);
    check_val("mm_state", 32'(state), 32'd7);
    check_val("mm_busy", 32'(busy), 32'd0);
    write_byte(8'hFF, ack);
    i2c_stop();
    check_val("mm_oe_cycles", 32'(oe_cnt - oe0), 32'd0);
    check_val("mm_rx_pulses", 32'(rx_cnt - rx0), 32'd0);
    check_val("mm_stop_state", 32'(state), 32'd0);

    // Single-byte read of 0x5A, master NACK
    tx_data = 8'h5A;
    tx0 = tx_cnt;
    i2c_start();
    write_byte(8'hA1, ack);
    check_val("rd_addr_ack", 32'(ack), 32'd1);
    check_val("rd_tx_req", 32'(tx_cnt - tx0), 32'd1);
    read_byte(rd);
    check_val("rd_byte", 32'(rd), 32'h5A);
    write_bit(1'b1);
    cyc(5);
    check_val("rd_nack_busy", 32'(busy), 32'd0);
    check_val("rd_nack_state", 32'(state), 32'd7);
    check_val("rd_tx_req_once", 32'(tx_cnt - tx0), 32'd1);
    i2c_stop();
    check_val("rd_stop_state", 32'(state), 32'd0);

    // Two-byte read, second byte 0xC3
    tx_data = 8'h5A;
    tx0 = tx_cnt;
    i2c_start();
    write_byte(8'hA1, ack);
    read_byte(rd);
    check_val("mr_byte0", 32'(rd), 32'h5A);
    tx_data = 8'hC3;
    write_bit(1'b0);
    read_byte(rd);
    check_val("mr_byte1", 32'(rd), 32'hC3);
    check_val("mr_tx_reqs", 32'(tx_cnt - tx0), 32'd2);
    write_bit(1'b1);
    i2c_stop();
    check_val("mr_stop_state", 32'(state), 32'd0);

    // Partial bytes aborted by STOP and by repeated START
    rx0 = rx_cnt;
    i2c_start();
    write_byte(8'hA0, ack);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    i2c_stop();
    check_val("ab_stop_state", 32'(state), 32'd0);
    i2c_start();
    write_byte(8'hA0, ack);
    write_bit(1'b0); write_bit(1'b1); write_bit(1'b1); write_bit(1'b0);
    i2c_start();
    check_val("ab_rstart_state", 32'(state), 32'd1);
    check_val("ab_no_rx", 32'(rx_cnt - rx0), 32'd0);
    write_byte(8'hA0, ack);
    write_byte(8'h81, ack);
    check_val("ab_data_ack", 32'(ack), 32'd1);
    cyc(5);
    check_val("ab_rx_data", 32'(rx_data), 32'h81);
    check_val("ab_rx_pulses", 32'(rx_cnt - rx0), 32'd1);
    i2c_stop();

    // Reset while the target drives the data ACK
    v3c = 8'h3C;
    i2c_start();
    write_byte(8'hA0, ack);
    for (int i = 7; i >= 0; i--) write_bit(v3c[i]);
    cyc(5);
    check_val("rs_pre_state", 32'(state), 32'd4);
    check_val("rs_pre_oe", 32'(sda_oe), 32'd1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check_val("rs_oe", 32'(sda_oe), 32'd0);
    check_val("rs_state", 32'(state), 32'd0);
    check_val("rs_rx_data", 32'(rx_data), 32'h00);
    cyc(5); scl_m = 1'b1;
    cyc(8); scl_m = 1'b0;
    cyc(5);
    check_val("rs_ignore_state", 32'(state), 32'd0);
    i2c_stop();
    rx0 = rx_cnt;
    i2c_start();
    write_byte(8'hA0, ack);
    check_val("rs_addr_ack", 32'(ack), 32'd1);
    write_byte(8'h3C, ack);
    cyc(5);
    check_val("rs_rx_data_new", 32'(rx_data), 32'h3C);
    check_val("rs_rx_pulses", 32'(rx_cnt - rx0), 32'd1);
    i2c_stop();
    check_val("rs_end_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
